// File: rtl/muldiv_ctrl_if.sv
// EX-side, multiplier, divider and HI/LO commit signals of the mul/div controller.
// The slave modport is the controller; master is the surrounding EX/unit environment.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        pipe_hold;

    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;

    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;

    logic        stallreq;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    modport master (
        output op_valid, op_type, opa, opb, annul, pipe_hold, mul_result, div_ready, div_result,
        input  mul_signed, mul_ina, mul_inb, div_start, div_signed, div_opa, div_opb, div_annul,
        input  stallreq, hi_we, lo_we, hi_o, lo_o, busy
    );

    modport slave (
        input  op_valid, op_type, opa, opb, annul, pipe_hold, mul_result, div_ready, div_result,
        output mul_signed, mul_ina, mul_inb, div_start, div_signed, div_opa, div_opb, div_annul,
        output stallreq, hi_we, lo_we, hi_o, lo_o, busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: latches one operation, stalls the pipe until the
// 64-bit result arrives, then issues a single HI/LO write once downstream is not held.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;

    localparam logic [2:0] CntInit = 3'(MUL_LAT - 1);

    state_e      state;
    logic [2:0]  cnt;
    logic [31:0] opa_r;
    logic [31:0] opb_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        sgn_r;
    logic        div_annul_r;
    logic        accept;

    assign accept = (state == StIdle) && bus.op_valid && !bus.annul;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            opa_r       <= '0;
            opb_r       <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            sgn_r       <= 1'b0;
            div_annul_r <= 1'b0;
        end else begin
            div_annul_r <= 1'b0;
            // Annul beats div_ready and cnt=0 in the same cycle.
            if (bus.annul) begin
                div_annul_r <= (state == StDivWait);
                state       <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (bus.op_valid) begin
                            opa_r <= bus.opa;
                            opb_r <= bus.opb;
                            sgn_r <= ~bus.op_type[0];
                            if (!bus.op_type[1]) begin
                                cnt   <= CntInit;
                                state <= StMulWait;
                            end else if (bus.opb == '0) begin
                                // Divide-by-zero: fixed result, divider is never started.
                                hi_r  <= bus.opa;
                                lo_r  <= 32'hFFFF_FFFF;
                                state <= StDone;
                            end else begin
                                state <= StDivWait;
                            end
                        end
                    end
                    StMulWait: begin
                        if (cnt == '0) begin
                            {hi_r, lo_r} <= bus.mul_result;
                            state        <= StDone;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    StDivWait: begin
                        if (bus.div_ready) begin
                            {hi_r, lo_r} <= bus.div_result;
                            state        <= StDone;
                        end
                    end
                    StDone: begin
                        if (!bus.pipe_hold) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.mul_signed = sgn_r;
    assign bus.mul_ina    = opa_r;
    assign bus.mul_inb    = opb_r;
    assign bus.div_signed = sgn_r;
    assign bus.div_opa    = opa_r;
    assign bus.div_opb    = opb_r;
    assign bus.div_start  = (state == StDivWait);
    assign bus.div_annul  = div_annul_r;
    assign bus.busy       = (state != StIdle);
    assign bus.hi_o       = hi_r;
    assign bus.lo_o       = lo_r;

    // Stall is released in DONE so EX advances in the commit cycle.
    assign bus.stallreq = !rst && (accept || (state == StMulWait) || (state == StDivWait));
    assign bus.hi_we    = !rst && (state == StDone) && !bus.pipe_hold && !bus.annul;
    assign bus.lo_we    = bus.hi_we;

endmodule
